// File: rtl/nn_layer_sequencer.sv
// ============================================================================
// Module   : nn_layer_sequencer
// Brief    : Runs a multi-layer FC network through one shared linear engine,
//            keeping the activation vector in a local buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_layer_sequencer #(
    parameter int FEATURES   = 11,
    parameter int NUM_LAYERS = 3,
    parameter int TIMEOUT    = 255,
    parameter int RELU_LAST  = 0,
    parameter int DATA_W     = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start_i,
    input  logic [FEATURES-1:0][DATA_W-1:0]                     in_vec_i,
    output logic                                                ready_o,
    output logic [(NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1)-1:0] layer_sel_o,
    output logic [FEATURES-1:0][DATA_W-1:0]                     eng_data_o,
    output logic                                                eng_go_o,
    input  logic [FEATURES-1:0][DATA_W-1:0]                     eng_data_i,
    input  logic                                                eng_valid_i,
    output logic [FEATURES-1:0][DATA_W-1:0]                     out_vec_o,
    output logic                                                out_valid_o,
    input  logic                                                out_ready_i,
    output logic                                                err_o
);

    localparam int c_layer_w = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int c_cnt_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_layer_w-1:0] c_last_layer = c_layer_w'(NUM_LAYERS - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_max    = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_OUTPUT = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t                           r_state;
    logic [c_layer_w-1:0]             r_layer;
    logic [c_cnt_w-1:0]               r_wait_cnt;
    logic [FEATURES-1:0][DATA_W-1:0]  r_buf;
    logic                             r_err;

    logic                             w_last;
    logic                             w_relu;
    logic [FEATURES-1:0][DATA_W-1:0]  w_act;

    assign w_last = (r_layer == c_last_layer);
    assign w_relu = !w_last || (RELU_LAST != 0);

    // Negative values (MSB set) clamp to zero only on layers that use ReLU.
    always_comb begin
        w_act = eng_data_i;
        for (int k = 0; k < FEATURES; k++) begin
            if (w_relu && eng_data_i[k][DATA_W-1]) begin
                w_act[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_layer    <= '0;
            r_wait_cnt <= '0;
            r_buf      <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_buf   <= in_vec_i;
                        r_layer <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    // A result arriving in the expiry cycle still wins.
                    if (eng_valid_i) begin
                        r_buf <= w_act;
                        if (w_last) begin
                            r_state <= S_OUTPUT;
                        end else begin
                            r_layer <= r_layer + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else if (r_wait_cnt == c_cnt_max) begin
                        r_state <= S_ERROR;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    r_err   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o     = (r_state == S_IDLE);
    assign eng_go_o    = (r_state == S_ISSUE);
    assign out_valid_o = (r_state == S_OUTPUT);
    assign err_o       = r_err;
    assign layer_sel_o = r_layer;
    assign eng_data_o  = r_buf;
    assign out_vec_o   = r_buf;

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
// ============================================================================
// Module   : tb_nn_layer_sequencer
// Brief    : Self-checking bench for nn_layer_sequencer with an engine model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_layer_sequencer;

    localparam int F  = 4;
    localparam int N  = 3;
    localparam int TO = 6;
    localparam int RL = 0;
    localparam int DW = 8;

    typedef logic [F-1:0][DW-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    vec_t       in_vec_i;
    logic       ready_o;
    logic [1:0] layer_sel_o;
    vec_t       eng_data_o;
    logic       eng_go_o;
    vec_t       eng_data_i;
    logic       eng_valid_i;
    vec_t       out_vec_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       err_o;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int eng_mode = 0;   // 0 normal, 1 never valid, 2 valid only in go cycle
    int eng_lat  = 1;
    int go_cnt   = 0;
    int sel_log  = 0;

    nn_layer_sequencer #(
        .FEATURES(F), .NUM_LAYERS(N), .TIMEOUT(TO), .RELU_LAST(RL), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .in_vec_i(in_vec_i),
        .ready_o(ready_o), .layer_sel_o(layer_sel_o), .eng_data_o(eng_data_o),
        .eng_go_o(eng_go_o), .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i),
        .out_vec_o(out_vec_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .err_o(err_o)
    );

    initial forever #5 clk = ~clk;

    function automatic vec_t eng_fn(vec_t x, int l);
        vec_t y;
        for (int k = 0; k < F; k++) begin
            y[k] = DW'(int'($signed(x[(k + 1) % F])) - int'($signed(x[k])) + l * 5 - 7);
        end
        return y;
    endfunction

    function automatic vec_t model(vec_t v);
        vec_t y;
        for (int l = 0; l < N; l++) begin
            y = eng_fn(v, l);
            for (int k = 0; k < F; k++) begin
                if ((l < N - 1 || RL != 0) && $signed(y[k]) < 0) y[k] = '0;
            end
            v = y;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine: answers eng_lat cycles after each go pulse.
    initial begin
        int   pend;
        vec_t pend_data;
        pend = 0;
        pend_data = '0;
        eng_valid_i = 1'b0;
        eng_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            eng_valid_i = 1'b0;
            eng_data_i  = vec_t'($urandom);
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    eng_valid_i = 1'b1;
                    eng_data_i  = pend_data;
                end
            end
            if (eng_go_o && eng_mode != 1) begin
                pend_data = eng_fn(eng_data_o, int'(layer_sel_o));
                if (eng_mode == 2) begin
                    eng_valid_i = 1'b1;
                    eng_data_i  = pend_data;
                end else begin
                    pend = eng_lat;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (eng_go_o) begin
            go_cnt  = go_cnt + 1;
            sel_log = sel_log * 4 + int'(layer_sel_o);
        end
    end

    task automatic run_inference(input vec_t v, input int lat, input int hold, input bit poke);
        int   cyc;
        int   exp_sel;
        vec_t exp_v;
        exp_v    = model(v);
        exp_sel  = 0;
        for (int l = 0; l < N; l++) exp_sel = exp_sel * 4 + l;
        eng_mode = 0;
        eng_lat  = lat;
        @(negedge clk);
        chk("ready_idle", ready_o, 1);
        go_cnt   = 0;
        sel_log  = 0;
        start_i  = 1'b1;
        in_vec_i = v;
        @(negedge clk);
        start_i  = 1'b0;
        in_vec_i = vec_t'($urandom);
        cyc = 1;
        chk("go_cycle1", eng_go_o, 1);
        chk("err_cleared", err_o, 0);
        while (!out_valid_o && cyc < 200) begin
            start_i = poke && (cyc == 3);
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        chk("valid_cycle", cyc, 1 + N * (lat + 1));
        chk("out_vec", out_vec_o, exp_v);
        chk("go_count", go_cnt, N);
        chk("sel_seq", sel_log, exp_sel);
        chk("err_low", err_o, 0);
        for (int h = 0; h < hold; h++) begin
            start_i = poke && (h == 0);
            @(negedge clk);
            start_i = 1'b0;
            chk("hold_valid", out_valid_o, 1);
            chk("hold_vec", out_vec_o, exp_v);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("valid_drop", out_valid_o, 0);
        chk("ready_back", ready_o, 1);
        chk("go_total", go_cnt, N);
    endtask

    task automatic run_timeout(input int mode, input int lat);
        int seen;
        seen = 0;
        eng_mode = mode;
        eng_lat  = lat;
        @(negedge clk);
        start_i  = 1'b1;
        in_vec_i = vec_t'($urandom);
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= TO + 3; cyc++) begin
            if (out_valid_o) seen++;
            if (cyc == TO + 2) chk("err_before", err_o, 0);
            if (cyc == TO + 3) begin
                chk("err_rise", err_o, 1);
                chk("ready_after_err", ready_o, 1);
            end
            if (cyc < TO + 3) @(negedge clk);
        end
        chk("no_valid_on_timeout", seen, 0);
        eng_mode = 0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        start_i = 1'b0;
        in_vec_i = '0;
        out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", ready_o, 1);
        chk("rst_go", eng_go_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_sel", layer_sel_o, 0);
        chk("rst_buf", eng_data_o, 0);
        chk("rst_out", out_vec_o, 0);

        v = {8'd3, 8'hF0, 8'd0, 8'h81};
        run_inference(v, 1, 4, 1'b0);
        v = {8'd0, 8'hFC, 8'd9, 8'd120};
        run_inference(v, 2, 0, 1'b1);

        run_timeout(1, 1);
        run_inference(vec_t'($urandom), 2, 1, 1'b0);
        run_timeout(2, 1);
        run_inference(vec_t'($urandom), TO, 0, 1'b0);
        run_timeout(0, TO + 1);
        run_inference(vec_t'($urandom), 1, 0, 1'b0);

        // Reset during WAIT of layer 1, then the late engine result must be dropped.
        eng_mode = 0;
        eng_lat  = 3;
        @(negedge clk);
        start_i  = 1'b1;
        in_vec_i = 32'h11223344;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_sel", layer_sel_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", ready_o, 1);
        chk("midrst_sel", layer_sel_o, 0);
        chk("midrst_buf", eng_data_o, 0);
        chk("midrst_valid", out_valid_o, 0);
        repeat (2) @(negedge clk);
        chk("late_ready", ready_o, 1);
        chk("late_buf", eng_data_o, 0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_inference(vec_t'($urandom), int'($urandom_range(1, TO)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
